// File: rtl/search_sequencer_pkg.sv
// Shared types and default sizes for the search sequencer slice.
package search_pkg;

  localparam int DEF_KEY_W    = 8;
  localparam int DEF_IDX_W    = 4;
  localparam int DEF_FIFO_DEP = 4;
  localparam int DEF_MAX_WAIT = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    OUT
  } state_t;

  typedef struct packed {
    logic [DEF_KEY_W-1:0] key;
    logic                 found;
    logic [DEF_IDX_W-1:0] idx;
    logic                 tmo;
  } result_t;

endpackage

// File: rtl/search_sequencer_if.sv
// Key stream, search-unit handshake and result stream of the search sequencer.
interface search_sequencer_if
  import search_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W,
  parameter int IDX_W = DEF_IDX_W
) ();

  logic             in_valid;
  logic [KEY_W-1:0] in_key;
  logic             in_ready;

  logic             srch_start;
  logic [KEY_W-1:0] srch_x;
  logic             srch_rdy;
  logic             srch_found;

  logic             out_valid;
  logic             out_ready;
  logic [KEY_W-1:0] out_key;
  logic             out_found;
  logic [IDX_W-1:0] out_idx;
  logic             out_tmo;

  logic             busy;

  // Sequencer side
  modport master (
    input  in_valid, in_key, srch_rdy, srch_found, out_ready,
    output in_ready, srch_start, srch_x, out_valid, out_key, out_found,
           out_idx, out_tmo, busy
  );

  // Environment side: key source, search unit and result sink
  modport slave (
    output in_valid, in_key, srch_rdy, srch_found, out_ready,
    input  in_ready, srch_start, srch_x, out_valid, out_key, out_found,
           out_idx, out_tmo, busy
  );

endinterface

// File: rtl/search_sequencer_key_fifo.sv
// Synchronous key FIFO; a push while full is taken only alongside a pop.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/search_sequencer.sv
// Buffers keys, launches one ROM search per key and returns the result.
module search_sequencer
  import search_pkg::*;
#(
  parameter int KEY_W    = DEF_KEY_W,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int FIFO_DEP = DEF_FIFO_DEP,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input logic                clk,
  input logic                reset,
  search_sequencer_if.master bus
);

  localparam int CW = $clog2(FIFO_DEP) + 1;
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(MAX_WAIT - 1);

  state_t           state_q;
  state_t           state_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [KEY_W-1:0] fifo_dout;
  logic [CW-1:0]    fifo_count;

  logic [IDX_W:0]   cnt_q;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] out_key_q;
  logic             out_found_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_tmo_q;

  logic             cnt_clr;
  logic             cnt_inc;
  logic             cap_en;
  logic             cap_found;
  logic [IDX_W-1:0] cap_idx;
  logic             cap_tmo;

  assign fifo_push = bus.in_valid && !fifo_full;

  key_fifo #(
    .DEPTH (FIFO_DEP),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (bus.in_key),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.in_ready   = !fifo_full;
  assign bus.srch_start = (state_q == LAUNCH);
  assign bus.srch_x     = key_q;
  assign bus.out_valid  = (state_q == OUT);
  assign bus.out_key    = out_key_q;
  assign bus.out_found  = out_found_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_tmo    = out_tmo_q;
  assign bus.busy       = (state_q != IDLE) || (fifo_count != '0);

  // Next state plus counter and result-capture controls
  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cap_en    = 1'b0;
    cap_found = 1'b0;
    cap_idx   = '1;
    cap_tmo   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        // srch_rdy here may still be left over from the previous search
        cnt_clr = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.srch_rdy) begin
          cap_en    = 1'b1;
          cap_found = bus.srch_found;
          cap_idx   = bus.srch_found ? cnt_q[IDX_W-1:0] : '1;
          state_d   = OUT;
        end else if (cnt_q == CNT_LAST) begin
          cap_en  = 1'b1;
          cap_tmo = 1'b1;
          state_d = OUT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, key under search, wait counter and result fields
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_q       <= '0;
      out_key_q   <= '0;
      out_found_q <= 1'b0;
      out_idx_q   <= '0;
      out_tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) key_q <= fifo_dout;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc && (cnt_q != CNT_LAST)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (cap_en) begin
        out_key_q   <= key_q;
        out_found_q <= cap_found;
        out_idx_q   <= cap_idx;
        out_tmo_q   <= cap_tmo;
      end
    end
  end

endmodule

// File: tb/tb_search_sequencer.sv
// Self-checking bench: search-unit model over ROM[i]=8'h10+i plus result scoreboard.
module tb_search_sequencer;
  import search_pkg::*;

  logic clk       = 1'b0;
  logic reset     = 1'b0;
  logic never_rdy = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  search_sequencer_if #(.KEY_W(8), .IDX_W(4)) bus ();

  search_sequencer #(
    .KEY_W    (8),
    .IDX_W    (4),
    .FIFO_DEP (4),
    .MAX_WAIT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Search unit model: one ROM index per cycle after srch_start; rdy stays high once done
  logic       m_busy  = 1'b0;
  logic       m_done  = 1'b0;
  logic       m_fnd   = 1'b0;
  logic [3:0] m_i     = 4'h0;
  logic [7:0] m_x     = 8'h00;
  logic       m_match;
  logic       m_hit;

  assign m_match        = ((8'h10 + {4'h0, m_i}) == m_x);
  assign m_hit          = m_busy && !never_rdy && (m_match || (m_i == 4'hF));
  assign bus.srch_rdy   = m_hit || m_done;
  assign bus.srch_found = m_busy ? m_match : m_fnd;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_fnd  <= 1'b0;
    end else if (bus.srch_start) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_i    <= 4'h0;
      m_x    <= bus.srch_x;
    end else if (m_hit) begin
      m_busy <= 1'b0;
      m_done <= 1'b1;
      m_fnd  <= m_match;
    end else if (m_busy && m_i != 4'hF) begin
      m_i <= m_i + 4'h1;
    end
  end

  // Reference: what a search of this key over the 16-entry ROM must report
  function automatic result_t expect_result(input logic [7:0] key, input logic never);
    result_t r;
    r.key = key;
    if (never) begin
      r.found = 1'b0; r.idx = 4'hF; r.tmo = 1'b1;
    end else if (key >= 8'h10 && key <= 8'h1F) begin
      r.found = 1'b1; r.idx = 4'(key - 8'h10); r.tmo = 1'b0;
    end else begin
      r.found = 1'b0; r.idx = 4'hF; r.tmo = 1'b0;
    end
    return r;
  endfunction

  // WAIT cycles spent before the result is taken
  function automatic int wait_cycles(input result_t r);
    return (r.found) ? int'(r.idx) + 1 : 16;
  endfunction

  task automatic send_key(input logic [7:0] k);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_key   = k;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_key: in_ready got 0 expected 1 within 100 cycles");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_start(output int ok);
    int n = 0;
    while (!bus.srch_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 50);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_start: srch_start got 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic idle_wait();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL idle_wait: busy got 1 expected 0 within 200 cycles");
    end
  endtask

  task automatic test_reset();
    logic [11:0] obs1;
    logic [13:0] obs2;
    reset = 1'b0;
    bus.in_valid = 1'b1; bus.in_key = 8'h55; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    obs1 = {bus.out_valid, bus.in_ready, bus.busy, bus.srch_start, bus.srch_x};
    checks++;
    if (obs1 !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected %h", obs1, {1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    end
    obs2 = {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo};
    checks++;
    if (obs2 !== 14'h0) begin
      errors++;
      $display("FAIL reset_fields: got %h expected %h", obs2, 14'h0);
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_push: busy got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_single();
    result_t e = expect_result(8'h13, 1'b0);
    int ok, steps = 0, starts = 0;
    bus.out_ready = 1'b1;
    send_key(8'h13);
    wait_start(ok);
    checks++;
    if (bus.srch_x !== 8'h13) begin
      errors++;
      $display("FAIL single_srch_x: got %h expected %h", bus.srch_x, 8'h13);
    end
    while (!bus.out_valid && steps < 40) begin
      @(negedge clk);
      steps++;
      if (bus.srch_start) starts++;
    end
    checks++;
    if (starts !== 0) begin
      errors++;
      $display("FAIL single_start_pulse: extra pulses got %0d expected 0", starts);
    end
    checks++;
    if (steps !== wait_cycles(e) + 1) begin
      errors++;
      $display("FAIL single_latency: got %0d expected %0d", steps, wait_cycles(e) + 1);
    end
    checks++;
    if ({bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo} !== e) begin
      errors++;
      $display("FAIL single_fields: got %h expected %h",
               {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo}, e);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: out_valid got %b expected 0", bus.out_valid);
    end
    idle_wait();
  endtask

  task automatic test_min_latency();
    result_t e = expect_result(8'h10, 1'b0);
    int steps = 0;
    bus.out_ready = 1'b1;
    send_key(8'h10);
    while (!bus.out_valid && steps < 20) begin
      @(negedge clk);
      steps++;
    end
    checks++;
    if (steps !== 3) begin
      errors++;
      $display("FAIL min_latency: cycles after key accept got %0d expected 3", steps);
    end
    checks++;
    if ({bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo} !== e) begin
      errors++;
      $display("FAIL min_latency_fields: got %h expected %h",
               {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo}, e);
    end
    @(negedge clk);
    idle_wait();
  endtask

  task automatic test_not_found();
    result_t e = expect_result(8'hFF, 1'b0);
    int ok, steps = 0;
    bus.out_ready = 1'b1;
    send_key(8'hFF);
    wait_start(ok);
    while (!bus.out_valid && steps < 40) begin
      @(negedge clk);
      steps++;
    end
    checks++;
    if (steps !== 17) begin
      errors++;
      $display("FAIL not_found_latency: got %0d expected 17", steps);
    end
    checks++;
    if ({bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo} !== e) begin
      errors++;
      $display("FAIL not_found_fields: got %h expected %h",
               {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo}, e);
    end
    @(negedge clk);
    idle_wait();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) send_key(8'(8'h10 + i));
      end
      begin
        for (int j = 0; j < 5; j++) begin
          result_t e = expect_result(8'(8'h10 + j), 1'b0);
          int n = 0;
          while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
          end
          checks++;
          if ({bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo} !== e || n >= 100) begin
            errors++;
            $display("FAIL b2b_result%0d: got %h expected %h", j,
                     {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo}, e);
          end
          @(negedge clk);
        end
      end
    join
    idle_wait();
  endtask

  task automatic test_backpressure();
    result_t   e = expect_result(8'h15, 1'b0);
    logic [13:0] held;
    int n = 0, accepted = 0, starts = 0, bad_hold = 0;
    bus.out_ready = 1'b0;
    send_key(8'h15);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    held = {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo};
    checks++;
    if (held !== e) begin
      errors++;
      $display("FAIL bp_first: got %h expected %h", held, e);
    end
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (c < 6);
      bus.in_key   = 8'(8'h16 + accepted);
      checks++;
      if (bus.in_ready !== (accepted < 4)) begin
        errors++;
        $display("FAIL bp_in_ready cycle %0d: got %b expected %b", c, bus.in_ready, accepted < 4);
      end
      if (bus.in_valid && bus.in_ready) accepted++;
      @(negedge clk);
      if (!bus.out_valid || {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo} !== held)
        bad_hold++;
      if (bus.srch_start) starts++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (accepted !== 4) begin
      errors++;
      $display("FAIL bp_fifo_depth: accepted got %0d expected 4", accepted);
    end
    checks++;
    if (bad_hold !== 0 || starts !== 0) begin
      errors++;
      $display("FAIL bp_hold: unstable cycles %0d, starts %0d; expected 0, 0", bad_hold, starts);
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      result_t ej = expect_result(8'(8'h15 + j), 1'b0);
      n = 0;
      while (!bus.out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if ({bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo} !== ej || n >= 100) begin
        errors++;
        $display("FAIL bp_drain%0d: got %h expected %h", j,
                 {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo}, ej);
      end
      @(negedge clk);
    end
    idle_wait();
  endtask

  task automatic test_timeout();
    result_t e = expect_result(8'h12, 1'b1);
    int ok, steps = 0;
    bus.out_ready = 1'b1;
    never_rdy = 1'b1;
    send_key(8'h12);
    wait_start(ok);
    while (!bus.out_valid && steps < 40) begin
      @(negedge clk);
      steps++;
    end
    checks++;
    if (steps !== 17) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected 17", steps);
    end
    checks++;
    if ({bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo} !== e) begin
      errors++;
      $display("FAIL timeout_fields: got %h expected %h",
               {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo}, e);
    end
    never_rdy = 1'b0;
    @(negedge clk);
    idle_wait();
  endtask

  task automatic test_reset_mid();
    int ok, seen = 0;
    logic [11:0] obs;
    bus.out_ready = 1'b1;
    send_key(8'hFF);
    send_key(8'h11);
    wait_start(ok);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    obs = {bus.out_valid, bus.in_ready, bus.busy, bus.srch_start, bus.srch_x};
    checks++;
    if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid || bus.srch_start || bus.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: active cycles got %0d expected 0", seen);
    end
  endtask

  task automatic test_random();
    result_t exp_q[$];
    result_t e;
    logic [13:0] prev;
    logic prev_stall = 1'b0;
    int sent = 0, cyc = 0;
    localparam int N = 40;
    while ((sent < N || exp_q.size() != 0) && cyc < 4000) begin
      if (prev_stall) begin
        checks++;
        if (!bus.out_valid || {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo} !== prev) begin
          errors++;
          $display("FAIL rnd_hold cycle %0d: got %b/%h expected 1/%h", cyc, bus.out_valid,
                   {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo}, prev);
        end
      end
      bus.in_valid  = (sent < N) && ($urandom_range(0, 1) == 1);
      bus.in_key    = ($urandom_range(0, 1) == 1) ? 8'(8'h10 + $urandom_range(0, 15))
                                                  : 8'($urandom_range(0, 255));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(expect_result(bus.in_key, 1'b0));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_unexpected: got result %h expected none",
                   {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo});
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo} !== e) begin
            errors++;
            $display("FAIL rnd_result: got %h expected %h",
                     {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo}, e);
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev = {bus.out_key, bus.out_found, bus.out_idx, bus.out_tmo};
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (sent !== N || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rnd_complete: sent %0d pending %0d expected %0d and 0", sent, exp_q.size(), N);
    end
    idle_wait();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_key    = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_min_latency();
    test_not_found();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
